// File: rtl/seq_mult_param.sv
//==============================================================================
// Module      : seq_mult_param
// Description : Shift-and-add sequential multiplier, one partial-product bit
//               per clock, signed/unsigned, start/ready/valid handshake.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic                 Signed_Mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     X,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Valid,
    output logic [2*WIDTH-1:0]   Result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mag_q, mag_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 valid_q, valid_d;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     x_mag;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;

    // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
    assign a_mag = (Signed_Mode && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign x_mag = (Signed_Mode && X[WIDTH-1]) ? (~X + 1'b1) : X;

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        valid_d  = 1'b0;
        addend   = {WIDTH{1'b0}};
        sum      = {(WIDTH+1){1'b0}};
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mag_d   = a_mag;
                    acc_d   = {{WIDTH{1'b0}}, x_mag};
                    cnt_d   = {CW{1'b0}};
                    neg_d   = Signed_Mode & (A[WIDTH-1] ^ X[WIDTH-1]);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                addend = acc_q[0] ? mag_q : {WIDTH{1'b0}};
                sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
                acc_d  = {sum, acc_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == C_LAST) begin
                    result_d = neg_q ? (~acc_d + 1'b1) : acc_d;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            mag_q    <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CW{1'b0}};
            neg_q    <= 1'b0;
            result_q <= {(2*WIDTH){1'b0}};
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign Ready  = (state_q == S_IDLE);
    assign Busy   = (state_q == S_CALC);
    assign Valid  = valid_q;
    assign Result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_param.sv
//==============================================================================
// Module      : tb_seq_mult_param
// Description : Randomised and directed bench for seq_mult_param (WIDTH 8 and 4)
//               against a cycle-count/arithmetic reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_mult_param;

    logic        clk;
    logic        rst_n;

    logic        start8, sm8;
    logic [7:0]  a8, x8;
    logic        ready8, busy8, valid8;
    logic [15:0] result8;

    logic        start4, sm4;
    logic [3:0]  a4, x4;
    logic        ready4, busy4, valid4;
    logic [7:0]  result4;

    int n_chk;
    int n_pass;
    int cyc;

    seq_mult_param #(.WIDTH(8)) u_dut8 (
        .Clock(clk), .Reset_n(rst_n), .Start(start8), .Signed_Mode(sm8),
        .A(a8), .X(x8), .Ready(ready8), .Busy(busy8), .Valid(valid8), .Result(result8)
    );

    seq_mult_param #(.WIDTH(4)) u_dut4 (
        .Clock(clk), .Reset_n(rst_n), .Start(start4), .Signed_Mode(sm4),
        .A(a4), .X(x4), .Ready(ready4), .Busy(busy4), .Valid(valid4), .Result(result4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference products computed with plain integer arithmetic.
    function automatic logic [15:0] ref8(input logic sm, input logic [7:0] a, input logic [7:0] x);
        longint p;
        if (sm) p = longint'($signed(a)) * longint'($signed(x));
        else    p = longint'(a) * longint'(x);
        return p[15:0];
    endfunction

    function automatic logic [7:0] ref4(input logic sm, input logic [3:0] a, input logic [3:0] x);
        longint p;
        if (sm) p = longint'($signed(a)) * longint'($signed(x));
        else    p = longint'(a) * longint'(x);
        return p[7:0];
    endfunction

    // Model: cycles remaining in the multiply, plus the registered Valid/Result.
    int          m8_rem, m4_rem;
    logic        m8_v, m4_v;
    logic [15:0] m8_r, m8_pend;
    logic [7:0]  m4_r, m4_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_rem = 0; m8_v = 1'b0; m8_r = 16'h0; m8_pend = 16'h0;
            m4_rem = 0; m4_v = 1'b0; m4_r = 8'h0;  m4_pend = 8'h0;
        end else begin
            m8_v = 1'b0;
            if (m8_rem > 0) begin
                m8_rem = m8_rem - 1;
                if (m8_rem == 0) begin m8_v = 1'b1; m8_r = m8_pend; end
            end else if (start8) begin
                m8_rem  = 8;
                m8_pend = ref8(sm8, a8, x8);
            end
            m4_v = 1'b0;
            if (m4_rem > 0) begin
                m4_rem = m4_rem - 1;
                if (m4_rem == 0) begin m4_v = 1'b1; m4_r = m4_pend; end
            end else if (start4) begin
                m4_rem  = 4;
                m4_pend = ref4(sm4, a4, x4);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        else n_pass++;
    endtask

    // Advance to the next falling edge and compare both DUTs with the model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("ready8",  64'(ready8),  64'(m8_rem == 0));
        chk("busy8",   64'(busy8),   64'(m8_rem != 0));
        chk("valid8",  64'(valid8),  64'(m8_v));
        chk("result8", 64'(result8), 64'(m8_r));
        chk("ready4",  64'(ready4),  64'(m4_rem == 0));
        chk("busy4",   64'(busy4),   64'(m4_rem != 0));
        chk("valid4",  64'(valid4),  64'(m4_v));
        chk("result4", 64'(result4), 64'(m4_r));
    endtask

    task automatic mul8(input logic sm, input logic [7:0] a, input logic [7:0] x, input logic [15:0] exp);
        int n;
        n = 0;
        while (!ready8 && n < 30) begin tick(); n++; end
        if (!ready8) chk("ready8_timeout", 64'd0, 64'd1);
        start8 = 1'b1; sm8 = sm; a8 = a; x8 = x;
        tick();
        start8 = 1'b0; sm8 = 1'($urandom); a8 = 8'($urandom); x8 = 8'($urandom);
        n = 0;
        while (!valid8 && n < 30) begin
            if (n == 3) start8 = 1'b1;
            if (n == 4) start8 = 1'b0;
            tick(); n++;
            a8 = 8'($urandom); x8 = 8'($urandom);
        end
        start8 = 1'b0;
        chk("latency8", 64'(n), 64'd8);
        chk("product8", 64'(result8), 64'(exp));
    endtask

    task automatic mul4(input logic sm, input logic [3:0] a, input logic [3:0] x, input logic [7:0] exp);
        int n;
        n = 0;
        while (!ready4 && n < 30) begin tick(); n++; end
        if (!ready4) chk("ready4_timeout", 64'd0, 64'd1);
        start4 = 1'b1; sm4 = sm; a4 = a; x4 = x;
        tick();
        start4 = 1'b0; sm4 = 1'($urandom); a4 = 4'($urandom); x4 = 4'($urandom);
        n = 0;
        while (!valid4 && n < 30) begin tick(); n++; end
        chk("latency4", 64'(n), 64'd4);
        chk("product4", 64'(result4), 64'(exp));
    endtask

    initial begin
        int last;
        logic [7:0] ra, rx;
        logic       rs;
        n_chk = 0; n_pass = 0; cyc = 0;
        rst_n = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; a8 = 8'h0; x8 = 8'h0;
        start4 = 1'b0; sm4 = 1'b0; a4 = 4'h0; x4 = 4'h0;
        tick(); tick();
        chk("reset_result8", 64'(result8), 64'd0);
        chk("reset_ready8",  64'(ready8),  64'd1);
        #2 rst_n = 1'b1;
        tick(); tick();

        // Directed products with hand-computed expectations
        mul8(1'b0, 8'd255, 8'd255, 16'hFE01);
        mul8(1'b1, 8'hFD,  8'd5,   16'hFFF1);
        mul8(1'b1, 8'h80,  8'h80,  16'h4000);
        mul8(1'b1, 8'h80,  8'h7F,  16'hC080);
        mul8(1'b0, 8'hFD,  8'd5,   16'h04F1);
        mul8(1'b1, 8'h00,  8'hFF,  16'h0000);
        mul8(1'b1, 8'hFF,  8'hFF,  16'h0001);

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rx = 8'($urandom); rs = 1'($urandom);
            mul8(rs, ra, rx, ref8(rs, ra, rx));
        end

        // Start held high with operands alternating every cycle
        last = -1;
        start8 = 1'b1; sm8 = 1'b1;
        for (int i = 0; i < 48; i++) begin
            a8 = (i % 2 == 1) ? 8'hFD : 8'h80;
            x8 = (i % 2 == 1) ? 8'h05 : 8'h7F;
            tick();
            if (valid8) begin
                if (last >= 0) chk("valid_spacing", 64'(i - last), 64'd9);
                last = i;
            end
        end
        start8 = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // Asynchronous reset during step 4
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; x8 = 8'd100;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready",  64'(ready8),  64'd1);
        chk("abort_busy",   64'(busy8),   64'd0);
        chk("abort_valid",  64'(valid8),  64'd0);
        chk("abort_result", 64'(result8), 64'd0);
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        mul8(1'b0, 8'd7, 8'd6, 16'h002A);

        // WIDTH=4 exhaustive sweeps
        chk("w4_pin_signed", 64'(ref4(1'b1, 4'h8, 4'h8)), 64'h40);
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int x = 0; x < 16; x++)
                    mul4(1'(s), 4'(a), 4'(x), ref4(1'(s), 4'(a), 4'(x)));
        mul4(1'b0, 4'hF, 4'hF, 8'hE1);
        mul4(1'b1, 4'hD, 4'h3, 8'hF7);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
